demux_frame_router: RTL and testbench



---
 rtl/demux_pkg.sv | 23 ++
 rtl/demux_frame_router_if.sv | 32 +++
 rtl/hold_timer.sv | 32 +++
 rtl/demux_frame_router.sv | 106 ++++++++++
 tb/tb_demux_frame_router.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types and frame constants for the demux frame router
// Contents:
//   state_t   : receive/drive FSM states
//   FRAME_LEN : bits per serial frame (start, S1, S0, D, stop)
//   PAYLOAD_W : payload bits captured into the shadow register
//   START_BIT, STOP_BIT : line levels that open and close a frame
package demux_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_S1,
        GET_S0,
        GET_D,
        GET_STOP,
        DRIVE
    } state_t;

    localparam int   FRAME_LEN = 5;
    localparam int   PAYLOAD_W = FRAME_LEN - 2;
    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/demux_frame_router_if.sv
// rtl/demux_frame_router_if.sv - serial input and demux-facing outputs of the frame router
// Signals:
//   sin        : serial frame input, one bit per clock
//   Sel0, Sel1 : demux selects (LSB, MSB)
//   Inp        : demux data input
//   busy       : frame being received or driven
//   frame_done : one-cycle pulse on a committed good frame
//   frame_err  : one-cycle pulse on a bad stop bit
//   frame_cnt  : count of committed good frames (wraps)
// Modports: master = router side, slave = line source / demux side.
interface demux_frame_router_if #(
    parameter int CNT_W = 8
);
    logic             sin;
    logic             Sel0;
    logic             Sel1;
    logic             Inp;
    logic             busy;
    logic             frame_done;
    logic             frame_err;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        input  sin,
        output Sel0, Sel1, Inp, busy, frame_done, frame_err, frame_cnt
    );

    modport slave (
        output sin,
        input  Sel0, Sel1, Inp, busy, frame_done, frame_err, frame_cnt
    );
endinterface

// File: rtl/hold_timer.sv
// rtl/hold_timer.sv - loadable down-counter timing the demux drive window
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   load     : load HOLD (takes priority over en)
//   en       : count down while nonzero
//   last     : high during the final cycle of the window
module hold_timer #(
    parameter int HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic last
);
    localparam int W = $clog2(HOLD + 1);

    logic [W-1:0] cnt;

    // The window is loaded with HOLD, so the count reads 1 in its final cycle.
    assign last = (cnt == W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(HOLD);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end
endmodule

// File: rtl/demux_frame_router.sv
// rtl/demux_frame_router.sv - serial frame decoder driving a 1:4 demux select/data
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : demux_frame_router_if.master (sin in; Sel0/Sel1/Inp, busy,
//              frame_done, frame_err, frame_cnt out)
// Parameters:
//   HOLD  : cycles Inp is driven per frame (1..255)
//   CNT_W : width of the delivered-frame counter
module demux_frame_router
    import demux_pkg::*;
#(
    parameter int HOLD  = 4,
    parameter int CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    demux_frame_router_if.master        bus
);
    state_t               state;
    logic [PAYLOAD_W-1:0] shadow;
    logic                 sel0_q;
    logic                 sel1_q;
    logic                 inp_q;
    logic                 done_q;
    logic                 err_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 good_stop;
    logic                 timer_last;

    assign good_stop = (state == GET_STOP) && (bus.sin == STOP_BIT);

    hold_timer #(
        .HOLD (HOLD)
    ) u_hold_timer (
        .clk  (clk),
        .rst  (rst),
        .load (good_stop),
        .en   (state == DRIVE),
        .last (timer_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            shadow <= '0;
            sel0_q <= 1'b0;
            sel1_q <= 1'b0;
            inp_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.sin == START_BIT) state <= GET_S1;
                end
                // Payload collects in the shadow only; live selects stay put
                // until the stop bit proves the frame good.
                GET_S1: begin
                    shadow <= {shadow[PAYLOAD_W-2:0], bus.sin};
                    state  <= GET_S0;
                end
                GET_S0: begin
                    shadow <= {shadow[PAYLOAD_W-2:0], bus.sin};
                    state  <= GET_D;
                end
                GET_D: begin
                    shadow <= {shadow[PAYLOAD_W-2:0], bus.sin};
                    state  <= GET_STOP;
                end
                GET_STOP: begin
                    if (good_stop) begin
                        // Both selects and data update on one edge: no glitch.
                        sel1_q <= shadow[2];
                        sel0_q <= shadow[1];
                        inp_q  <= shadow[0];
                        done_q <= 1'b1;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        state  <= DRIVE;
                    end else begin
                        // The bad stop bit is consumed, never reused as a start.
                        err_q <= 1'b1;
                        state <= IDLE;
                    end
                end
                DRIVE: begin
                    if (timer_last) begin
                        inp_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Sel0       = sel0_q;
    assign bus.Sel1       = sel1_q;
    assign bus.Inp        = inp_q;
    assign bus.busy       = (state != IDLE);
    assign bus.frame_done = done_q;
    assign bus.frame_err  = err_q;
    assign bus.frame_cnt  = cnt_q;
endmodule

// File: tb/tb_demux_frame_router.sv
// tb/tb_demux_frame_router.sv - randomized self-checking bench for demux_frame_router
module tb_demux_frame_router;
    localparam int HOLD  = 4;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    demux_frame_router_if #(.CNT_W(CNT_W)) bus ();

    demux_frame_router #(
        .HOLD  (HOLD),
        .CNT_W (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // The downstream 1:4 demux.
    logic [3:0] y;
    assign y = bus.Inp ? (4'b0001 << {bus.Sel1, bus.Sel0}) : 4'b0000;

    int n_checks = 0;
    int n_errors = 0;
    int ycnt [4];

    // Reference state: what the outputs must be, derived from frame rules.
    logic m_sel1, m_sel0, m_inp;
    int   m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) ycnt[i] += int'(y[i]);
    endtask

    task automatic check_all(input logic e_busy, input logic e_done, input logic e_err);
        logic [3:0] e_y;
        e_y = m_inp ? (4'b0001 << (2 * int'(m_sel1) + int'(m_sel0))) : 4'b0000;
        chk("sel1",  bus.Sel1, m_sel1);
        chk("sel0",  bus.Sel0, m_sel0);
        chk("inp",   bus.Inp, m_inp);
        chk("busy",  bus.busy, e_busy);
        chk("done",  bus.frame_done, e_done);
        chk("err",   bus.frame_err, e_err);
        chk("cnt",   bus.frame_cnt, m_cnt);
        chk("demux", y, e_y);
    endtask

    function automatic logic fill_bit(input int fill);
        return (fill == 2) ? logic'($urandom_range(0, 1)) : logic'(fill[0]);
    endfunction

    // Sends one frame starting in an IDLE cycle and checks every cycle until
    // the DUT is back in IDLE. fill: value of sin during DRIVE (0, 1, 2=random).
    task automatic send_frame(input logic s1, input logic s0, input logic d,
                              input logic bad, input int fill);
        bus.sin = 1'b1; tick(); check_all(1'b1, 1'b0, 1'b0);
        bus.sin = s1;   tick(); check_all(1'b1, 1'b0, 1'b0);
        bus.sin = s0;   tick(); check_all(1'b1, 1'b0, 1'b0);
        bus.sin = d;    tick(); check_all(1'b1, 1'b0, 1'b0);
        bus.sin = bad;  tick();
        if (!bad) begin
            m_sel1 = s1; m_sel0 = s0; m_inp = d;
            m_cnt  = (m_cnt + 1) % (1 << CNT_W);
            check_all(1'b1, 1'b1, 1'b0);
            for (int k = 1; k < HOLD; k++) begin
                bus.sin = fill_bit(fill); tick(); check_all(1'b1, 1'b0, 1'b0);
            end
            bus.sin = fill_bit(fill); tick();
            m_inp = 1'b0;
            check_all(1'b0, 1'b0, 1'b0);
        end else begin
            check_all(1'b0, 1'b0, 1'b1);
            bus.sin = 1'b0; tick(); check_all(1'b0, 1'b0, 1'b0);
        end
        bus.sin = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        bus.sin = 1'b0;
        for (int k = 0; k < n; k++) begin
            tick(); check_all(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic clear_model();
        m_sel1 = 1'b0; m_sel0 = 1'b0; m_inp = 1'b0; m_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.sin = 1'b0; tick();
        rst = 1'b0; clear_model();
        check_all(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.sin = 1'b0;
        clear_model();
        for (int i = 0; i < 4; i++) ycnt[i] = 0;
        rst = 1'b1;
        tick(); tick();
        check_all(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        idle_cycles(2);

        // Single frame 1,1,0,1,0 -> Y2 high for HOLD cycles.
        for (int i = 0; i < 4; i++) ycnt[i] = 0;
        send_frame(1'b1, 1'b0, 1'b1, 1'b0, 0);
        chk("y2_width", ycnt[2], HOLD);
        chk("cnt_one", bus.frame_cnt, 1);

        // All four selects back-to-back at minimum spacing.
        do_reset();
        for (int i = 0; i < 4; i++) ycnt[i] = 0;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] s;
            s = 2'(i);
            send_frame(s[1], s[0], 1'b1, 1'b0, 2);
        end
        for (int i = 0; i < 4; i++) chk("y_width", ycnt[i], HOLD);
        chk("cnt_four", bus.frame_cnt, 4);

        // Bad stop 1,0,1,1,1 then a good frame.
        send_frame(1'b0, 1'b1, 1'b1, 1'b1, 0);
        send_frame(1'b1, 1'b1, 1'b1, 1'b0, 2);

        // Reset in the middle of a frame.
        bus.sin = 1'b1; tick(); check_all(1'b1, 1'b0, 1'b0);
        bus.sin = 1'b1; tick(); check_all(1'b1, 1'b0, 1'b0);
        rst = 1'b1; bus.sin = 1'b1; tick();
        rst = 1'b0; clear_model();
        check_all(1'b0, 1'b0, 1'b0);
        idle_cycles(3);

        // Reset during DRIVE.
        send_frame(1'b0, 1'b1, 1'b1, 1'b0, 2);
        bus.sin = 1'b1; tick(); check_all(1'b1, 1'b0, 1'b0);
        bus.sin = 1'b1; tick(); check_all(1'b1, 1'b0, 1'b0);
        bus.sin = 1'b0; tick(); check_all(1'b1, 1'b0, 1'b0);
        bus.sin = 1'b1; tick(); check_all(1'b1, 1'b0, 1'b0);
        bus.sin = 1'b0; tick();
        m_sel1 = 1'b1; m_sel0 = 1'b0; m_inp = 1'b1; m_cnt = m_cnt + 1;
        check_all(1'b1, 1'b1, 1'b0);
        bus.sin = 1'b0; tick(); check_all(1'b1, 1'b0, 1'b0);
        rst = 1'b1; tick();
        rst = 1'b0; clear_model();
        check_all(1'b0, 1'b0, 1'b0);
        idle_cycles(2);

        // sin held high through DRIVE is ignored.
        send_frame(1'b1, 1'b0, 1'b1, 1'b0, 1);
        idle_cycles(1);

        // Random mix of good/bad frames, gaps and fill.
        for (int n = 0; n < 40; n++) begin
            send_frame(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                       logic'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 2);
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
        end

        // Counter wrap over 256 commits.
        do_reset();
        for (int n = 0; n < 255; n++) begin
            send_frame(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                       logic'($urandom_range(0, 1)), 1'b0, 2);
        end
        chk("cnt_255", bus.frame_cnt, 255);
        send_frame(1'b0, 1'b0, 1'b1, 1'b0, 2);
        chk("cnt_wrap", bus.frame_cnt, 0);
        idle_cycles(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
